// File: rtl/ifmap_bank_ring_pkg.sv
// Shared configuration for the ifmap bank ring: default widths,
// one-hot bank-state encoding and the ring-pointer helper.
package ifmap_bank_ring_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int NUM_BANKS_DEF  = 2;

    typedef logic [5:0] bank_st_t;

    localparam bank_st_t ST_EMPTY    = 6'b000001;
    localparam bank_st_t ST_FILLING  = 6'b000010;
    localparam bank_st_t ST_FULL     = 6'b000100;
    localparam bank_st_t ST_BUSY     = 6'b001000;
    localparam bank_st_t ST_RESULT   = 6'b010000;
    localparam bank_st_t ST_DRAINING = 6'b100000;

    function automatic int ring_next(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/bank_sp_ram.sv
// One bank of the ring: read-first storage with a registered read port,
// one read and one write per cycle.
module bank_sp_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ifmap_bank_ring.sv
// N-bank ifmap/result buffer rotating banks through fill, compute and
// drain, with a 2-entry skid FIFO on the readback path.
module ifmap_bank_ring
    import ifmap_bank_ring_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_BANKS  = NUM_BANKS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    input  logic                  w_last,
    output logic                  w_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  r_last,
    input  logic                  r_ready,
    input  logic [ADDR_WIDTH:0]   tensor_size,
    input  logic                  conv_start,
    input  logic                  conv_done,
    output logic                  cmp_ready,
    input  logic [ADDR_WIDTH-1:0] tensor_addr,
    input  logic                  t_addr_vld,
    output logic [DATA_WIDTH-1:0] tensor_data,
    output logic                  tensor_vld,
    input  logic [ADDR_WIDTH-1:0] result_addr,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  result_w_vld,
    output logic                  err_overflow
);

    localparam int PW = $clog2(NUM_BANKS);
    typedef logic [PW-1:0] ptr_t;

    bank_st_t [NUM_BANKS-1:0] st_q, st_d;
    ptr_t wr_ptr_q, wr_ptr_d, cmp_ptr_q, cmp_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d, t_bank_q, t_bank_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH:0] dr_size_q, dr_size_d, dr_addr_q, dr_addr_d;
    logic w_ready_q, w_ready_d, err_q, err_d, tvld_q, tvld_d;
    logic pend_q, pend_d, pend_last_q, pend_last_d;
    logic [DATA_WIDTH-1:0] sk0_data_q, sk0_data_d, sk1_data_q, sk1_data_d;
    logic sk0_last_q, sk0_last_d, sk1_last_q, sk1_last_d;
    logic [1:0] sk_cnt_q, sk_cnt_d, sk_left;

    logic [NUM_BANKS-1:0] ram_we, ram_re;
    logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] ram_wa, ram_ra;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] ram_wd, ram_rd;

    logic any_busy, fill_acc, cmp_rd, dr_issue, pop;

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++)
            any_busy = any_busy | (st_q[i] == ST_BUSY);
    end

    assign r_valid   = (sk_cnt_q != 2'd0);
    assign pop       = r_valid & r_ready;
    assign fill_acc  = w_valid & w_ready_q;
    assign cmp_ready = (st_q[cmp_ptr_q] == ST_FULL) & ~any_busy;
    assign cmp_rd    = enable & t_addr_vld & (st_q[cmp_ptr_q] == ST_BUSY);

    // Issue only if the landing beat still fits after this cycle's pop.
    assign dr_issue = enable & (st_q[rd_ptr_q] == ST_DRAINING)
                    & (dr_addr_q < dr_size_q)
                    & (({1'b0, sk_cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        st_d        = st_q;
        wr_ptr_d    = wr_ptr_q;
        cmp_ptr_d   = cmp_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        w_addr_d    = w_addr_q;
        err_d       = err_q;
        dr_size_d   = dr_size_q;
        dr_addr_d   = dr_addr_q;
        pend_d      = dr_issue;
        pend_last_d = dr_issue & (dr_addr_q == dr_size_q - 1'b1);
        tvld_d      = cmp_rd;
        t_bank_d    = cmp_rd ? cmp_ptr_q : t_bank_q;
        sk0_data_d  = sk0_data_q;
        sk0_last_d  = sk0_last_q;
        sk1_data_d  = sk1_data_q;
        sk1_last_d  = sk1_last_q;

        if (fill_acc) begin
            st_d[wr_ptr_q] = ST_FILLING;
            if (w_last || (&w_addr_q)) begin
                st_d[wr_ptr_q] = ST_FULL;
                wr_ptr_d = ptr_t'(ring_next(int'(wr_ptr_q), NUM_BANKS));
                w_addr_d = '0;
                if (!w_last) err_d = 1'b1;
            end else begin
                w_addr_d = w_addr_q + 1'b1;
            end
        end

        if (enable && conv_done && st_q[cmp_ptr_q] == ST_BUSY) begin
            st_d[cmp_ptr_q] = ST_RESULT;
            cmp_ptr_d = ptr_t'(ring_next(int'(cmp_ptr_q), NUM_BANKS));
        end else if (enable && conv_start && cmp_ready) begin
            st_d[cmp_ptr_q] = ST_BUSY;
        end

        if (enable && st_q[rd_ptr_q] == ST_RESULT) begin
            if (tensor_size == '0) begin
                st_d[rd_ptr_q] = ST_EMPTY;
                rd_ptr_d = ptr_t'(ring_next(int'(rd_ptr_q), NUM_BANKS));
            end else begin
                st_d[rd_ptr_q] = ST_DRAINING;
                dr_size_d = tensor_size;
                dr_addr_d = '0;
            end
        end
        if (dr_issue) dr_addr_d = dr_addr_q + 1'b1;
        if (pop && sk0_last_q) begin
            st_d[rd_ptr_q] = ST_EMPTY;
            rd_ptr_d = ptr_t'(ring_next(int'(rd_ptr_q), NUM_BANKS));
        end

        sk_left = sk_cnt_q - {1'b0, pop};
        if (pop) begin
            sk0_data_d = sk1_data_q;
            sk0_last_d = sk1_last_q;
        end
        if (pend_q) begin
            if (sk_left == 2'd0) begin
                sk0_data_d = ram_rd[rd_ptr_q];
                sk0_last_d = pend_last_q;
            end else begin
                sk1_data_d = ram_rd[rd_ptr_q];
                sk1_last_d = pend_last_q;
            end
        end
        sk_cnt_d = sk_left + {1'b0, pend_q};

        w_ready_d = enable & ((st_d[wr_ptr_d] == ST_EMPTY)
                            | (st_d[wr_ptr_d] == ST_FILLING));
    end

    // Ownership follows bank state, so at most one agent drives each port.
    always_comb begin
        ram_we = '0;
        ram_wa = '0;
        ram_wd = '0;
        ram_re = '0;
        ram_ra = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (fill_acc && ptr_t'(i) == wr_ptr_q) begin
                ram_we[i] = 1'b1;
                ram_wa[i] = w_addr_q;
                ram_wd[i] = w_data;
            end else if (result_w_vld && st_q[i] == ST_BUSY) begin
                ram_we[i] = 1'b1;
                ram_wa[i] = result_addr;
                ram_wd[i] = result_data;
            end
            if (cmp_rd && ptr_t'(i) == cmp_ptr_q) begin
                ram_re[i] = 1'b1;
                ram_ra[i] = tensor_addr;
            end else if (dr_issue && ptr_t'(i) == rd_ptr_q) begin
                ram_re[i] = 1'b1;
                ram_ra[i] = dr_addr_q[ADDR_WIDTH-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_sp_ram #(
            .WIDTH (DATA_WIDTH),
            .AW    (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[g]),
            .waddr (ram_wa[g]),
            .wdata (ram_wd[g]),
            .re    (ram_re[g]),
            .raddr (ram_ra[g]),
            .rdata (ram_rd[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= {NUM_BANKS{ST_EMPTY}};
            wr_ptr_q    <= '0;
            cmp_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            t_bank_q    <= '0;
            w_addr_q    <= '0;
            dr_size_q   <= '0;
            dr_addr_q   <= '0;
            w_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            tvld_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            sk0_data_q  <= '0;
            sk0_last_q  <= 1'b0;
            sk1_data_q  <= '0;
            sk1_last_q  <= 1'b0;
            sk_cnt_q    <= '0;
        end else begin
            st_q        <= st_d;
            wr_ptr_q    <= wr_ptr_d;
            cmp_ptr_q   <= cmp_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            t_bank_q    <= t_bank_d;
            w_addr_q    <= w_addr_d;
            dr_size_q   <= dr_size_d;
            dr_addr_q   <= dr_addr_d;
            w_ready_q   <= w_ready_d;
            err_q       <= err_d;
            tvld_q      <= tvld_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            sk0_data_q  <= sk0_data_d;
            sk0_last_q  <= sk0_last_d;
            sk1_data_q  <= sk1_data_d;
            sk1_last_q  <= sk1_last_d;
            sk_cnt_q    <= sk_cnt_d;
        end
    end

    assign w_ready      = w_ready_q;
    assign r_data       = sk0_data_q;
    assign r_last       = r_valid & sk0_last_q;
    assign tensor_vld   = tvld_q;
    assign tensor_data  = tvld_q ? ram_rd[t_bank_q] : '0;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_ifmap_bank_ring.sv
// Directed-sequence bench for ifmap_bank_ring with random data, checked
// against a bank-level model of states, pointers and stored words.
module tb_ifmap_bank_ring;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NB    = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, enable;
    logic [DW-1:0] w_data, r_data, tensor_data, result_data;
    logic w_valid, w_last, w_ready, r_valid, r_last, r_ready;
    logic [AW:0] tensor_size;
    logic conv_start, conv_done, cmp_ready, t_addr_vld, tensor_vld;
    logic [AW-1:0] tensor_addr, result_addr;
    logic result_w_vld, err_overflow;

    always #5 clk = ~clk;

    ifmap_bank_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .w_data(w_data), .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready),
        .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
        .tensor_size(tensor_size), .conv_start(conv_start), .conv_done(conv_done),
        .cmp_ready(cmp_ready), .tensor_addr(tensor_addr), .t_addr_vld(t_addr_vld),
        .tensor_data(tensor_data), .tensor_vld(tensor_vld),
        .result_addr(result_addr), .result_data(result_data),
        .result_w_vld(result_w_vld), .err_overflow(err_overflow)
    );

    typedef enum int {M_EMPTY, M_FILLING, M_FULL, M_BUSY, M_RESULT} mst_e;
    mst_e mst [NB];
    int wp, cp, rp, wa;
    bit ovf;
    logic [DW-1:0] bmem [NB][DEPTH];
    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mst[i] = M_EMPTY;
        wp = 0; cp = 0; rp = 0; wa = 0; ovf = 0;
    endtask

    task automatic status(input string tag);
        bit busy = 0;
        for (int i = 0; i < NB; i++) if (mst[i] == M_BUSY) busy = 1;
        chk({tag, ".w_ready"}, w_ready,
            enable && (mst[wp] == M_EMPTY || mst[wp] == M_FILLING));
        chk({tag, ".cmp_ready"}, cmp_ready, mst[cp] == M_FULL && !busy);
        chk({tag, ".overflow"}, err_overflow, ovf);
    endtask

    task automatic fill(input int n, input bit use_last, input int base);
        int i = 0;
        int t = 0;
        while (i < n && t < 100) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = (base >= 0) ? DW'(base + i) : DW'($urandom);
            w_last  = use_last && (i == n - 1);
            if (w_ready) begin
                bmem[wp][wa] = w_data;
                mst[wp] = M_FILLING;
                wa++;
                if (w_last || wa == DEPTH) begin
                    if (!w_last) ovf = 1;
                    mst[wp] = M_FULL;
                    wp = (wp + 1) % NB;
                    wa = 0;
                end
                i++;
            end
            t++;
        end
        @(negedge clk);
        w_valid = 1'b0;
        w_last  = 1'b0;
        chk("fill_beats", i, n);
    endtask

    task automatic start_conv();
        @(negedge clk);
        status("pre_start");
        conv_start = 1'b1;
        @(negedge clk);
        conv_start = 1'b0;
        mst[cp] = M_BUSY;
        status("busy");
    endtask

    // Reads each address while overwriting it: the read must see old data.
    task automatic compute(input int n);
        logic [DW-1:0] exp_q = '0;
        logic [DW-1:0] nd;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("tensor_vld", tensor_vld, 1'b1);
                chk("tensor_data", tensor_data, exp_q);
            end
            t_addr_vld   = (i < n);
            result_w_vld = (i < n);
            if (i < n) begin
                tensor_addr = AW'(i);
                result_addr = AW'(i);
                nd = DW'($urandom);
                result_data = nd;
                exp_q = bmem[cp][i];
                bmem[cp][i] = nd;
            end
        end
        @(negedge clk);
        chk("tensor_vld_idle", tensor_vld, 1'b0);
    endtask

    // conv_start rides along with conv_done and must be ignored.
    task automatic finish_conv(input int size);
        @(negedge clk);
        tensor_size = (AW + 1)'(size);
        conv_done  = 1'b1;
        conv_start = 1'b1;
        @(negedge clk);
        conv_done  = 1'b0;
        conv_start = 1'b0;
        mst[cp] = M_RESULT;
        cp = (cp + 1) % NB;
    endtask

    task automatic drain(input int n, input bit toggle, input int abort_at);
        int k = 0;
        int t = 0;
        int first = -1;
        bit stall = 0;
        logic [DW-1:0] held = '0;
        while (k < n && t < 200 && !(abort_at >= 0 && k == abort_at)) begin
            @(negedge clk);
            t++;
            if (stall) begin
                chk("r_hold_valid", r_valid, 1'b1);
                chk("r_hold_data", r_data, held);
            end
            r_ready = toggle ? t[0] : 1'b1;
            stall = r_valid && !r_ready;
            held = r_data;
            if (r_valid && r_ready) begin
                chk("r_data", r_data, bmem[rp][k]);
                chk("r_last", r_last, k == n - 1);
                if (first < 0) first = t;
                k++;
            end
        end
        if (abort_at >= 0) return;
        chk("drain_beats", k, n);
        if (!toggle) chk("drain_rate", t - first, n - 1);
        @(negedge clk);
        r_ready = 1'b0;
        mst[rp] = M_EMPTY;
        rp = (rp + 1) % NB;
        chk("r_valid_after", r_valid, 1'b0);
        status("drained");
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        w_data = '0; w_valid = 0; w_last = 0; r_ready = 0;
        tensor_size = '0; conv_start = 0; conv_done = 0;
        tensor_addr = '0; t_addr_vld = 0;
        result_addr = '0; result_data = '0; result_w_vld = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_data", r_data, '0);
        chk("rst_r_last", r_last, 1'b0);
        chk("rst_cmp_ready", cmp_ready, 1'b0);
        chk("rst_tensor_vld", tensor_vld, 1'b0);
        chk("rst_tensor_data", tensor_data, '0);
        chk("rst_overflow", err_overflow, 1'b0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        status("idle");

        fill(4, 1'b1, 'h11);
        status("b0_full");

        enable = 1'b0;
        conv_start = 1'b1;
        @(negedge clk);
        conv_start = 1'b0;
        status("en_off");
        enable = 1'b1;
        @(negedge clk);
        status("en_on");

        start_conv();
        compute(4);
        finish_conv(4);
        drain(4, 1'b0, -1);

        fill(5, 1'b1, -1);
        start_conv();
        compute(5);
        finish_conv(5);
        drain(5, 1'b1, -1);

        fill(6, 1'b1, -1);
        fill(3, 1'b1, -1);
        fill(4, 1'b1, -1);
        status("ring_full");
        start_conv();
        compute(6);
        finish_conv(6);
        status("next_full_waits");
        drain(6, 1'b0, -1);

        start_conv();
        compute(3);
        finish_conv(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("size0_no_beat", r_valid, 1'b0);
        end
        mst[rp] = M_EMPTY;
        rp = (rp + 1) % NB;
        status("size0");

        fill(DEPTH, 1'b0, -1);
        status("overflow");
        fill(3, 1'b1, -1);
        status("after_overflow");

        start_conv();
        compute(4);
        finish_conv(4);
        drain(4, 1'b1, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_r_valid", r_valid, 1'b0);
        chk("midrst_r_last", r_last, 1'b0);
        chk("midrst_w_ready", w_ready, 1'b0);
        chk("midrst_cmp_ready", cmp_ready, 1'b0);
        chk("midrst_overflow", err_overflow, 1'b0);
        @(negedge clk);
        r_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        status("post_rst");

        fill(2, 1'b1, -1);
        start_conv();
        compute(2);
        finish_conv(2);
        drain(2, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
